// File: rtl/rgb_pkg.sv
// Shared types for the RGB LED channel blocks.
//   DUTY_W       : default duty width in bits
//   duty_t       : duty / target value type
//   ramp_state_t : slew limiter ramp state
package rgb_pkg;

  localparam int DUTY_W = 8;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN
  } ramp_state_t;

endpackage

// File: rtl/duty_slew_limiter_if.sv
// Control/status bundle between a channel controller and its duty slew limiter.
//   target    : requested duty (controller -> limiter)
//   enable    : 1 = ramp advances, 0 = freeze
//   bypass    : 1 = duty follows target directly
//   duty_out  : applied duty (limiter -> controller / pwm)
//   ramping   : 1 while a ramp is in progress
//   at_target : 1 when applied duty equals the registered target
interface duty_slew_limiter_if #(
  parameter int DUTY_W = rgb_pkg::DUTY_W
);

  logic [DUTY_W-1:0] target;
  logic              enable;
  logic              bypass;
  logic [DUTY_W-1:0] duty_out;
  logic              ramping;
  logic              at_target;

  modport master (
    output target, enable, bypass,
    input  duty_out, ramping, at_target
  );

  modport slave (
    input  target, enable, bypass,
    output duty_out, ramping, at_target
  );

endinterface

// File: rtl/tick_prescaler.sv
// Rate divider: counts 0..DIV-1 while run=1 and flags the last count with tick.
//   clk   : clock
//   rst   : synchronous active-high reset (count -> 0)
//   clear : synchronous clear (count -> 0), overrides run
//   run   : advance the count this cycle; 0 holds it
//   tick  : 1 while count == DIV-1
module tick_prescaler #(
  parameter int DIV = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int            CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (run) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/duty_slew_limiter.sv
// Rate-limits changes of a PWM duty so fast target changes and count wraps fade smoothly.
// Moves duty_out toward the registered target by at most STEP_SIZE every
// STEP_DIV cycles, treating target as an unsigned magnitude (255->0 ramps
// down through every value).
//   clk           : system clock
//   rst           : synchronous active-high reset
//   bus.target    : requested duty, registered into target_q every cycle
//   bus.enable    : 0 freezes duty_out, state and prescaler
//   bus.bypass    : 1 loads duty_out from target_q directly (priority over enable)
//   bus.duty_out  : applied duty (registered)
//   bus.ramping   : 1 while state is UP or DOWN (registered)
//   bus.at_target : 1 when duty_out == target_q (registered)
//
// state | meaning
// IDLE  | duty_out equals target_q, prescaler parked at 0
// UP    | target_q above duty_out, step up on each prescaler tick
// DOWN  | target_q below duty_out, step down on each prescaler tick
module duty_slew_limiter #(
  parameter int DUTY_W    = 8,
  parameter int STEP_DIV  = 1024,
  parameter int STEP_SIZE = 1
) (
  input  logic                clk,
  input  logic                rst,
  duty_slew_limiter_if.slave  bus
);

  import rgb_pkg::*;

  localparam logic [DUTY_W-1:0] STEP = DUTY_W'(STEP_SIZE);

  logic [DUTY_W-1:0] target_q;
  logic [DUTY_W-1:0] duty_q;
  ramp_state_t       state;

  logic [DUTY_W-1:0] dist_up, dist_dn, step_up, step_dn;
  logic [DUTY_W-1:0] duty_nxt;
  ramp_state_t       state_nxt;
  logic              tick, presc_clear, presc_run;

  // Leaving IDLE always starts a fresh interval; direction reversals keep
  // the running interval so an oscillating target does not stall the ramp.
  assign presc_clear = bus.bypass || (bus.enable && state == IDLE);
  assign presc_run   = bus.enable && !bus.bypass && state != IDLE;

  tick_prescaler #(.DIV(STEP_DIV)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .clear (presc_clear),
    .run   (presc_run),
    .tick  (tick)
  );

  // Step is clamped to the remaining distance, so no overshoot or wrap.
  assign dist_up = target_q - duty_q;
  assign dist_dn = duty_q - target_q;
  assign step_up = (dist_up < STEP) ? dist_up : STEP;
  assign step_dn = (dist_dn < STEP) ? dist_dn : STEP;

  always_comb begin
    duty_nxt  = duty_q;
    state_nxt = state;
    if (bus.bypass) begin
      duty_nxt  = target_q;
      state_nxt = IDLE;
    end else if (bus.enable) begin
      case (state)
        IDLE: begin
          if (target_q > duty_q)      state_nxt = UP;
          else if (target_q < duty_q) state_nxt = DOWN;
        end
        UP, DOWN: begin
          if (target_q > duty_q) begin
            if (tick) duty_nxt = duty_q + step_up;
            state_nxt = (duty_nxt == target_q) ? IDLE : UP;
          end else if (target_q < duty_q) begin
            if (tick) duty_nxt = duty_q - step_dn;
            state_nxt = (duty_nxt == target_q) ? IDLE : DOWN;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Flags are derived from the values being loaded this edge so they line
  // up with duty_out; at_target compares against the incoming target.
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q      <= '0;
      duty_q        <= '0;
      state         <= IDLE;
      bus.ramping   <= 1'b0;
      bus.at_target <= 1'b1;
    end else begin
      target_q      <= bus.target;
      duty_q        <= duty_nxt;
      state         <= state_nxt;
      bus.ramping   <= (state_nxt != IDLE);
      bus.at_target <= (duty_nxt == bus.target);
    end
  end

  assign bus.duty_out = duty_q;

endmodule

// File: tb/tb_duty_slew_limiter.sv
module tb_duty_slew_limiter;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  duty_slew_limiter_if #(.DUTY_W(8)) bus_a ();
  duty_slew_limiter_if #(.DUTY_W(8)) bus_b ();

  duty_slew_limiter #(.DUTY_W(8), .STEP_DIV(DIV), .STEP_SIZE(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  duty_slew_limiter #(.DUTY_W(8), .STEP_DIV(DIV), .STEP_SIZE(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  // Reference: registered target, applied duty, whether a ramp is active and
  // how many cycles of the current step interval have elapsed.
  typedef struct {
    int tq;
    int duty;
    int phase;
    bit active;
  } ref_t;

  typedef struct {
    int duty;
    bit ramping;
    bit at_tgt;
  } exp_t;

  ref_t ma, mb;
  exp_t qa[$];
  exp_t qb[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic ref_t ref_step(ref_t m, bit r, int tgt, bit en, bit byp, int step);
    ref_t n;
    int gap, mag, mv;
    n = m;
    if (r) begin
      n.tq = 0; n.duty = 0; n.phase = 0; n.active = 0;
      return n;
    end
    n.tq = tgt;
    if (byp) begin
      n.duty = m.tq; n.active = 0; n.phase = 0;
    end else if (en) begin
      if (!m.active) begin
        if (m.tq != m.duty) begin
          n.active = 1; n.phase = 0;
        end
      end else if (m.tq == m.duty) begin
        n.active = 0;
      end else begin
        if (m.phase == DIV - 1) begin
          gap = m.tq - m.duty;
          mag = (gap < 0) ? -gap : gap;
          mv  = (mag < step) ? mag : step;
          n.duty  = m.duty + ((gap > 0) ? mv : -mv);
          n.phase = 0;
        end else begin
          n.phase = m.phase + 1;
        end
        n.active = (n.duty != m.tq);
      end
    end
    return n;
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit r, int tgt, bit en, bit byp);
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus_a.target = 8'(tgt); bus_a.enable = en; bus_a.bypass = byp;
    bus_b.target = 8'(tgt); bus_b.enable = en; bus_b.bypass = byp;
    ma = ref_step(ma, r, tgt, en, byp, 1);
    mb = ref_step(mb, r, tgt, en, byp, 16);
    e.duty = ma.duty; e.ramping = ma.active; e.at_tgt = (ma.duty == ma.tq);
    qa.push_back(e);
    e.duty = mb.duty; e.ramping = mb.active; e.at_tgt = (mb.duty == mb.tq);
    qb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUTs present outputs; compare with the queued model.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      check("a.duty_out",  int'(bus_a.duty_out),  e.duty);
      check("a.ramping",   int'(bus_a.ramping),   int'(e.ramping));
      check("a.at_target", int'(bus_a.at_target), int'(e.at_tgt));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      check("b.duty_out",  int'(bus_b.duty_out),  e.duty);
      check("b.ramping",   int'(bus_b.ramping),   int'(e.ramping));
      check("b.at_target", int'(bus_b.at_target), int'(e.at_tgt));
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int start, first1, n, last_chg, prev, idx, tgt;
    int seen_b[$];
    bit en, byp, r;

    ma = '{0, 0, 0, 0};
    mb = '{0, 0, 0, 0};
    bus_a.target = '0; bus_a.enable = 1'b1; bus_a.bypass = 1'b0;
    bus_b.target = '0; bus_b.enable = 1'b1; bus_b.bypass = 1'b0;

    // 1. reset held with target 200, then release
    for (int i = 0; i < 3; i++) begin
      drive(1, 200, 1, 0);
      check("rst.duty", int'(bus_a.duty_out), 0);
      check("rst.ramping", int'(bus_a.ramping), 0);
      check("rst.at_target", int'(bus_a.at_target), 1);
    end
    start = -1; first1 = -1;
    for (int k = 1; k <= 40 && first1 < 0; k++) begin
      drive(0, 200, 1, 0);
      if (start < 0 && bus_a.ramping) start = k;
      if (first1 < 0 && bus_a.duty_out == 8'd1) first1 = k;
    end
    check("rel.ramp_start", start, 2);
    check("rel.first_step_delay", first1 - start, 4);

    // 2. step 0 -> 10
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 10, 1, 0);
    n = 0; last_chg = 0; prev = 0;
    for (int k = 1; k <= 100; k++) begin
      drive(0, 10, 1, 0);
      if (int'(bus_a.duty_out) != prev) begin
        check("step10.increment", int'(bus_a.duty_out) - prev, 1);
        if (last_chg > 0) check("step10.interval", k - last_chg, DIV);
        last_chg = k;
        prev = int'(bus_a.duty_out);
      end
      if (bus_a.duty_out == 8'd10) begin n = k; break; end
    end
    check("step10.latency", n, 41);
    check("step10.ramping_done", int'(bus_a.ramping), 0);
    check("step10.at_target", int'(bus_a.at_target), 1);

    // 3. wrap 255 -> 0, reversal at 250 toward 252
    for (int i = 0; i < 3; i++) drive(0, 255, 1, 1);
    check("wrap.preload", int'(bus_a.duty_out), 255);
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      drive(0, 0, 1, 0);
      if (bus_a.duty_out == 8'd250) begin n = k; break; end
    end
    check("wrap.reached_250", int'(bus_a.duty_out), 250);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      drive(0, 252, 1, 0);
      if (bus_a.duty_out != 8'd250) begin n = k; break; end
    end
    check("rev.first_value", int'(bus_a.duty_out), 251);
    check("rev.no_presc_reset", n, DIV);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      drive(0, 252, 1, 0);
      if (bus_a.duty_out != 8'd251) begin n = k; break; end
    end
    check("rev.second_value", int'(bus_a.duty_out), 252);
    check("rev.interval", n, DIV);
    check("rev.idle", int'(bus_a.ramping), 0);

    // 4. STEP_SIZE=16, 0 -> 40
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    prev = 0;
    for (int k = 1; k <= 60; k++) begin
      drive(0, 40, 1, 0);
      if (int'(bus_b.duty_out) != prev) begin
        prev = int'(bus_b.duty_out);
        seen_b.push_back(prev);
      end
    end
    check("big.count", seen_b.size(), 3);
    idx = 0;
    foreach (seen_b[i]) begin
      check("big.value", seen_b[i], (i == 2) ? 40 : 16 * (i + 1));
      idx++;
    end
    check("big.idle", int'(bus_b.ramping), 0);
    check("big.at_target", int'(bus_b.at_target), 1);

    // 5. freeze mid-ramp at duty 5
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    for (int k = 1; k <= 100; k++) begin
      drive(0, 10, 1, 0);
      if (bus_a.duty_out == 8'd5) break;
    end
    check("frz.reached_5", int'(bus_a.duty_out), 5);
    drive(0, 10, 1, 0);
    drive(0, 10, 1, 0);
    for (int k = 0; k < 20; k++) begin
      drive(0, 10, 0, 0);
      if (k % 5 == 4) check("frz.hold", int'(bus_a.duty_out), 5);
    end
    check("frz.ramping_held", int'(bus_a.ramping), 1);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      drive(0, 10, 1, 0);
      if (bus_a.duty_out != 8'd5) begin n = k; break; end
    end
    check("frz.remaining", n, 2);
    check("frz.next_value", int'(bus_a.duty_out), 6);

    // 6. bypass with enable=0, then reset mid-ramp
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1);
    drive(0, 180, 0, 1);
    check("byp.lag1", int'(bus_a.duty_out), 0);
    drive(0, 180, 0, 1);
    check("byp.lag2", int'(bus_a.duty_out), 180);
    check("byp.at_target", int'(bus_a.at_target), 1);
    for (int i = 0; i < 10; i++) drive(0, 20, 1, 0);
    check("byp.ramping", int'(bus_a.ramping), 1);
    drive(1, 20, 1, 0);
    check("rst_mid.duty", int'(bus_a.duty_out), 0);
    check("rst_mid.ramping", int'(bus_a.ramping), 0);
    check("rst_mid.at_target", int'(bus_a.at_target), 1);

    // Randomised traffic
    tgt = 20;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 11) == 0) tgt = int'($urandom_range(0, 255));
      en  = ($urandom_range(0, 9) != 0);
      byp = ($urandom_range(0, 59) == 0);
      r   = ($urandom_range(0, 399) == 0);
      drive(r, tgt, en, byp);
    end

    @(negedge clk);
    @(negedge clk);
    check("queue.drain", qa.size() + qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
